// File: rtl/vm_timeout_ctrl_if.sv
// Handshake bundle between the vending datapath and the inactivity timer.
// Strobes flow master->slave; the timer status flows back, with no backpressure.
interface vm_timeout_ctrl_if #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int CNT_W     = 32
);
    logic [NUM_COINS-1:0] i_input_coin;
    logic [NUM_ITEMS-1:0] i_select_item;
    logic [NUM_ITEMS-1:0] i_available_item;
    logic                 i_trigger_return;
    logic                 i_return_finished;
    logic [CNT_W-1:0]     o_wait_time;
    logic                 o_return_req;
    logic                 o_timeout_pulse;
    logic [1:0]           o_state;

    modport master (
        output i_input_coin, i_select_item, i_available_item,
               i_trigger_return, i_return_finished,
        input  o_wait_time, o_return_req, o_timeout_pulse, o_state
    );

    modport slave (
        input  i_input_coin, i_select_item, i_available_item,
               i_trigger_return, i_return_finished,
        output o_wait_time, o_return_req, o_timeout_pulse, o_state
    );
endinterface

// File: rtl/vm_timeout_ctrl.sv
// Inactivity countdown with prescaler; raises a return request on expiry or trigger.
// All outputs registered (1-cycle latency from strobes); no backpressure, strobes never stall.
module vm_timeout_ctrl #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int WAIT_TIME = 100,
    parameter int CNT_W     = 32,
    parameter int TICK_DIV  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    vm_timeout_ctrl_if.slave bus
);
    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_TIME);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RET   = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             pulse_q, pulse_d;
    logic             req_q, req_d;

    logic [NUM_COINS-1:0] coin_vec;
    logic [NUM_ITEMS-1:0] sel_vec;
    logic                 coin, valid_sel, activity, tick;

    assign coin_vec  = bus.i_input_coin;
    assign sel_vec   = bus.i_select_item & bus.i_available_item;
    assign coin      = |coin_vec;
    assign valid_sel = |sel_vec;
    assign activity  = coin | valid_sel;
    assign tick      = (state_q == ST_ARMED) && (presc_q == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= WAIT_VAL;
            presc_q <= '0;
            pulse_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (coin) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.i_trigger_return)            state_d = ST_RET;
                else if (activity)                   state_d = ST_ARMED;
                else if (tick && cnt_q == CNT_W'(1)) state_d = ST_RET;
            end
            ST_RET: begin
                if (bus.i_return_finished) state_d = coin ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        pulse_d = 1'b0;
        req_d   = (state_d == ST_RET);
        case (state_q)
            ST_ARMED: begin
                if (bus.i_trigger_return) begin
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (activity) begin
                    cnt_d   = WAIT_VAL;
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else if (cnt_q != '0) begin
                        // Saturate at zero rather than wrap
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_RET: begin
                presc_d = '0;
                cnt_d   = bus.i_return_finished ? WAIT_VAL : '0;
            end
            default: begin
                cnt_d   = WAIT_VAL;
                presc_d = '0;
            end
        endcase
    end

    assign bus.o_wait_time     = cnt_q;
    assign bus.o_return_req    = req_q;
    assign bus.o_timeout_pulse = pulse_q;
    assign bus.o_state         = state_q;
endmodule

// File: tb/tb_vm_timeout_ctrl.sv
// Bench for vm_timeout_ctrl: unit A (WAIT_TIME=5, TICK_DIV=2) from a vector table, unit B (WAIT_TIME=1, TICK_DIV=1) by hand.
module tb_vm_timeout_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vm_timeout_ctrl_if #(.NUM_COINS(3), .NUM_ITEMS(4), .CNT_W(32)) bus_a ();
    vm_timeout_ctrl_if #(.NUM_COINS(3), .NUM_ITEMS(4), .CNT_W(32)) bus_b ();

    vm_timeout_ctrl #(.NUM_COINS(3), .NUM_ITEMS(4), .WAIT_TIME(5), .CNT_W(32), .TICK_DIV(2))
        u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    vm_timeout_ctrl #(.NUM_COINS(3), .NUM_ITEMS(4), .WAIT_TIME(1), .CNT_W(32), .TICK_DIV(1))
        u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    typedef struct {
        logic [2:0] coin;
        logic [3:0] sel;
        logic [3:0] avail;
        logic       trig;
        logic       fin;
        logic [1:0] st;
        int         cnt;
        logic       req;
        logic       pls;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic [2:0] c, logic [3:0] s, logic [3:0] a, logic t, logic f,
                                logic [1:0] st, int cnt, logic r, logic p);
        vec_t v;
        v.coin = c; v.sel = s; v.avail = a; v.trig = t; v.fin = f;
        v.st = st; v.cnt = cnt; v.req = r; v.pls = p;
        return v;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [1:0] st, input int cnt, input logic r, input logic p);
        check({tag, "_state"}, bus_a.o_state, st);
        check({tag, "_wait"},  bus_a.o_wait_time, cnt);
        check({tag, "_req"},   bus_a.o_return_req, r);
        check({tag, "_pulse"}, bus_a.o_timeout_pulse, p);
    endtask

    task automatic check_b(input string tag, input logic [1:0] st, input int cnt, input logic r, input logic p);
        check({tag, "_state"}, bus_b.o_state, st);
        check({tag, "_wait"},  bus_b.o_wait_time, cnt);
        check({tag, "_req"},   bus_b.o_return_req, r);
        check({tag, "_pulse"}, bus_b.o_timeout_pulse, p);
    endtask

    task automatic clear_a();
        bus_a.i_input_coin = '0; bus_a.i_select_item = '0; bus_a.i_available_item = '0;
        bus_a.i_trigger_return = 1'b0; bus_a.i_return_finished = 1'b0;
    endtask

    // Drive one vector, queue its expectation, then retire it after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        bus_a.i_input_coin = v.coin; bus_a.i_select_item = v.sel; bus_a.i_available_item = v.avail;
        bus_a.i_trigger_return = v.trig; bus_a.i_return_finished = v.fin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        clear_a();
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_a(tag, e.st, e.cnt, e.req, e.pls);
        end
    endtask

    initial begin
        clear_a();
        bus_b.i_input_coin = '0; bus_b.i_select_item = '0; bus_b.i_available_item = '0;
        bus_b.i_trigger_return = 1'b0; bus_b.i_return_finished = 1'b0;

        // Timeout path, then ignored inputs in RETURNING and IDLE
        tbl.push_back(mk(3'b001, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 2, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 2, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 1, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 1, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b10, 0, 1, 1));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b10, 0, 1, 0));
        tbl.push_back(mk(3'b001, 4'h0, 4'h0, 0, 0, 2'b10, 0, 1, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 1, 0, 2'b10, 0, 1, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 1, 2'b00, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h1, 4'h1, 0, 0, 2'b00, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 1, 0, 2'b00, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 1, 2'b00, 5, 0, 0));
        // Purchase reload, unavailable select, multi-bit strobes, trigger with coin
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h2, 4'h2, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h4, 4'h3, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 2, 0, 0));
        tbl.push_back(mk(3'b011, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'hF, 4'h8, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b001, 4'h0, 4'h0, 1, 0, 2'b10, 0, 1, 0));
        tbl.push_back(mk(3'b001, 4'h0, 4'h0, 0, 1, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 1, 0, 2'b10, 0, 1, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 1, 2'b00, 5, 0, 0));
        // Unavailable select mid-count, then hold at counter=2 for the reset test
        tbl.push_back(mk(3'b100, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 4, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h1, 4'hE, 0, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 2, 0, 0));
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b01, 2, 0, 0));

        #12;
        check_a("rst_a", 2'b00, 5, 0, 0);
        check_b("rst_b", 2'b00, 1, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Asynchronous reset mid-count, observed before the next edge
        #2 reset_n = 1'b0;
        #1 check_a("arst_a", 2'b00, 5, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(mk(3'b000, 4'h0, 4'h0, 0, 0, 2'b00, 5, 0, 0), "post_rst0");
        apply(mk(3'b000, 4'h3, 4'h3, 0, 0, 2'b00, 5, 0, 0), "post_rst1");
        apply(mk(3'b001, 4'h0, 4'h0, 0, 0, 2'b01, 5, 0, 0), "post_rst2");

        // Unit B: immediate expiry and saturation while held in RETURNING
        @(negedge clk);
        bus_b.i_input_coin = 3'b001;
        @(posedge clk);
        #1;
        bus_b.i_input_coin = 3'b000;
        check_b("b_arm", 2'b01, 1, 0, 0);
        @(posedge clk);
        #1 check_b("b_expire", 2'b10, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 check_b($sformatf("b_hold%0d", k), 2'b10, 0, 1, 0);
        end
        #2 reset_n = 1'b0;
        #1 check_b("b_arst", 2'b00, 1, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_b("b_idle", 2'b00, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vm_timeout_ctrl.md
Name: vm_timeout_ctrl

Overview:
Parametrised inactivity timer and return sequencer for the vending machine datapath. It arms on the first coin, reloads on every coin or valid purchase, and counts down at a prescaled rate. On expiry, or on a user return trigger, it raises a return request and holds it until the change-return logic reports completion. It supersedes the fixed-width wait-time counter, adding the prescaler, an explicit FSM, a saturating count, and timeout/return handshake outputs.

Parameters:
NUM_COINS, 3, width of coin-insert vector
NUM_ITEMS, 4, width of item select/available vectors
WAIT_TIME, 100, reload value of countdown, in ticks (>=1)
CNT_W, 32, counter width; WAIT_TIME must fit in CNT_W bits
TICK_DIV, 1, clock cycles per countdown tick (>=1); prescaler width = max(1, clog2(TICK_DIV))

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_input_coin  in  NUM_COINS  one-hot-or-zero coin insert strobe, one cycle per coin
i_select_item  in  NUM_ITEMS  item select strobe
i_available_item  in  NUM_ITEMS  per-item purchasable flag, same cycle as select
i_trigger_return  in  1  user return request, one-cycle strobe
i_return_finished  in  1  change-return logic done, one-cycle strobe
o_wait_time  out  CNT_W  current countdown value
o_return_req  out  1  level; high while in RETURNING
o_timeout_pulse  out  1  one-cycle pulse when the countdown expires (not on manual trigger)
o_state  out  2  00 IDLE, 01 ARMED, 10 RETURNING

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_wait_time=WAIT_TIME, prescaler=0, o_return_req=0, o_timeout_pulse=0.
- coin = |i_input_coin. valid_sel = |(i_select_item & i_available_item). activity = coin | valid_sel. Selecting an unavailable item is not activity.
- tick: prescaler counts 0..TICK_DIV-1 in ARMED only. tick is high when prescaler==TICK_DIV-1, and the prescaler wraps to 0 on that edge. With TICK_DIV=1, tick is high every cycle.
- IDLE: counter held at WAIT_TIME, prescaler held at 0. coin -> ARMED, counter=WAIT_TIME. valid_sel and i_trigger_return are ignored.
- ARMED, evaluated in priority order:
  1. i_trigger_return -> RETURNING, counter=0, no timeout pulse.
  2. activity -> counter=WAIT_TIME, prescaler=0, stay ARMED.
  3. tick with counter==1 -> counter=0, RETURNING, o_timeout_pulse=1 for exactly the next cycle.
  4. tick -> counter-1.
  5. otherwise hold.
- Counter never underflows: it saturates at 0 and never wraps to all-ones.
- RETURNING: o_return_req=1, counter held at 0, prescaler held at 0.
  - Coin, select and trigger are ignored, except that i_return_finished and coin in the same cycle -> ARMED, counter=WAIT_TIME.
  - i_return_finished alone -> IDLE, counter=WAIT_TIME.
- o_return_req and o_state are registered and reflect the current state. o_timeout_pulse is registered, 1 cycle wide.
- i_return_finished outside RETURNING has no effect.
- Reset asserted mid-countdown or mid-return returns to reset values immediately, with no pulse.
- Multiple coin bits or multiple select bits in one cycle count as a single activity event.

Test Plan:
- WAIT_TIME=5, TICK_DIV=2. Coin strobe at edge E0 -> ARMED, wait_time=5. It decrements at E2, E4, E6 and E8, reaching 4,3,2,1, and reaches 0 at E10 -> state=RETURNING, o_timeout_pulse high only for the cycle after E10, o_return_req=1.
- Same setup, valid purchase at E5 (counter=3) -> counter=5, prescaler=0, next decrement at E7. Selecting an unavailable item at E5 instead -> no reload, counter=2 at E6.
- ARMED with counter=3: i_trigger_return asserted together with a coin -> RETURNING, counter=0, o_timeout_pulse stays 0. Then i_return_finished -> IDLE, wait_time=5, o_return_req=0.
- In RETURNING: coin alone -> state unchanged. i_return_finished together with coin -> ARMED, wait_time=5.
- TICK_DIV=1, WAIT_TIME=1. Coin, then no activity -> RETURNING on the next edge and timeout pulse. Holding RETURNING for 20 cycles keeps wait_time=0, with no wrap to 2^CNT_W-1.
- Drive reset_n low asynchronously mid-count (counter=2, ARMED) -> outputs go to IDLE/WAIT_TIME/0 before the next clk edge. After release, the block is idle until a coin arrives.
